// File: rtl/eth_rx_fsm.sv
// ---------------------------------------------------------------------------
// eth_rx_fsm
//
// Receive-side Ethernet framer. Consumes one byte per receive clock, already
// assembled from the RGMII DDR input, strips the preamble and SFD, captures
// and optionally filters the destination MAC, captures the source MAC, writes
// payload bytes (EtherType onward, FCS excluded) into RX memory and checks
// the IEEE 802.3 FCS. Every frame that gets past the SFD ends with either a
// valid pulse, an error pulse, or a silent drop (address filter miss).
//
// Ports
//   i_eth_clk        receive clock, all logic on its rising edge
//   i_rst            synchronous active-high reset
//   i_rx_dv          byte valid
//   i_rx_er          receive error
//   i_rx_data        received byte
//   i_mac_filter_en  1 = accept only i_mac_addr or broadcast
//   i_mac_addr       local MAC, first byte on the wire is [47:40]
//   o_mem_wr_en      payload byte write strobe
//   o_mem_wr_addr    payload write address, first payload byte at 0
//   o_mem_wr_data    payload byte
//   o_frame_valid    one-cycle pulse, frame accepted
//   o_frame_error    one-cycle pulse, frame errored
//   o_frame_size     payload length of the last completed frame
//   o_src_mac        source MAC of the last completed frame
//   o_busy           high from SFD accepted until back to idle
// ---------------------------------------------------------------------------
module eth_rx_fsm #(
    parameter int unsigned MIN_PREAMBLE = 2,
    parameter int unsigned MAX_PAYLOAD  = 1504
) (
    input  logic        i_eth_clk,
    input  logic        i_rst,
    input  logic        i_rx_dv,
    input  logic        i_rx_er,
    input  logic [7:0]  i_rx_data,
    input  logic        i_mac_filter_en,
    input  logic [47:0] i_mac_addr,
    output logic        o_mem_wr_en,
    output logic [15:0] o_mem_wr_addr,
    output logic [7:0]  o_mem_wr_data,
    output logic        o_frame_valid,
    output logic        o_frame_error,
    output logic [15:0] o_frame_size,
    output logic [47:0] o_src_mac,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_MAC_DES,
        S_MAC_SRC,
        S_PAYLOAD,
        S_DONE,
        S_DROP
    } state_t;

    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;

    // One byte of the reflected CRC-32, data bits consumed LSB first.
    function automatic logic [31:0] crcByte(input logic [31:0] crcIn,
                                            input logic [7:0]  dataIn);
        logic [31:0] c;
        c = crcIn ^ {24'd0, dataIn};
        for (int b = 0; b < 8; b++) begin
            if (c[0]) c = (c >> 1) ^ CRC_POLY;
            else      c = c >> 1;
        end
        return c;
    endfunction

    state_t      state_q,      state_d;
    logic        arm_q,        arm_d;
    logic [7:0]  pcnt_q,       pcnt_d;
    logic [2:0]  macCnt_q,     macCnt_d;
    logic [47:0] dstMac_q,     dstMac_d;
    logic [47:0] srcShift_q,   srcShift_d;
    logic [31:0] crc_q,        crc_d;
    logic [15:0] n_q,          n_d;
    logic [31:0] dly_q,        dly_d;
    logic        memWrEn_q,    memWrEn_d;
    logic [15:0] memWrAddr_q,  memWrAddr_d;
    logic [7:0]  memWrData_q,  memWrData_d;
    logic        frameValid_q, frameValid_d;
    logic        frameError_q, frameError_d;
    logic [15:0] frameSize_q,  frameSize_d;
    logic [47:0] srcMac_q,     srcMac_d;
    logic        busy_q,       busy_d;

    logic [47:0] dstNext;
    logic [15:0] nNext;
    logic [31:0] fcsCalc;
    logic        fcsGood;
    logic        dstMatch;

    // State and datapath registers. Reset is synchronous; arm is cleared so a
    // frame already on the wire when reset lifts is ignored until dv drops.
    always_ff @(posedge i_eth_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            arm_q        <= 1'b0;
            pcnt_q       <= 8'd0;
            macCnt_q     <= 3'd0;
            dstMac_q     <= 48'd0;
            srcShift_q   <= 48'd0;
            crc_q        <= CRC_INIT;
            n_q          <= 16'd0;
            dly_q        <= 32'd0;
            memWrEn_q    <= 1'b0;
            memWrAddr_q  <= 16'd0;
            memWrData_q  <= 8'd0;
            frameValid_q <= 1'b0;
            frameError_q <= 1'b0;
            frameSize_q  <= 16'd0;
            srcMac_q     <= 48'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            arm_q        <= arm_d;
            pcnt_q       <= pcnt_d;
            macCnt_q     <= macCnt_d;
            dstMac_q     <= dstMac_d;
            srcShift_q   <= srcShift_d;
            crc_q        <= crc_d;
            n_q          <= n_d;
            dly_q        <= dly_d;
            memWrEn_q    <= memWrEn_d;
            memWrAddr_q  <= memWrAddr_d;
            memWrData_q  <= memWrData_d;
            frameValid_q <= frameValid_d;
            frameError_q <= frameError_d;
            frameSize_q  <= frameSize_d;
            srcMac_q     <= srcMac_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and output logic. All outputs are registered, so every
    // pulse or write appears one cycle after the input byte that caused it.
    always_comb begin
        state_d      = state_q;
        arm_d        = arm_q | ~i_rx_dv;
        pcnt_d       = pcnt_q;
        macCnt_d     = macCnt_q;
        dstMac_d     = dstMac_q;
        srcShift_d   = srcShift_q;
        crc_d        = crc_q;
        n_d          = n_q;
        dly_d        = dly_q;
        memWrEn_d    = 1'b0;
        memWrAddr_d  = memWrAddr_q;
        memWrData_d  = memWrData_q;
        frameValid_d = 1'b0;
        frameError_d = 1'b0;
        frameSize_d  = frameSize_q;
        srcMac_d     = srcMac_q;
        busy_d       = busy_q;

        dstNext  = {dstMac_q[39:0], i_rx_data};
        nNext    = n_q + 16'd1;
        fcsCalc  = ~crc_q;
        // The delay line holds the last four bytes, oldest in [31:24]; the FCS
        // is sent least significant byte first.
        fcsGood  = (dly_q[31:24] == fcsCalc[7:0])   &&
                   (dly_q[23:16] == fcsCalc[15:8])  &&
                   (dly_q[15:8]  == fcsCalc[23:16]) &&
                   (dly_q[7:0]   == fcsCalc[31:24]);
        dstMatch = (dstNext == i_mac_addr) || (dstNext == BCAST_MAC);

        case (state_q)
            // S_DONE behaves like idle so a frame separated by a single dv=0
            // cycle still sees its first preamble byte.
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (arm_q && i_rx_dv) begin
                    if (i_rx_data == PRE_BYTE) begin
                        state_d = S_PREAMBLE;
                        pcnt_d  = 8'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end

            S_PREAMBLE: begin
                if (!i_rx_dv) begin
                    state_d = S_IDLE;
                end else if (i_rx_data == PRE_BYTE) begin
                    if (pcnt_q != 8'hFF) pcnt_d = pcnt_q + 8'd1;
                end else if (i_rx_data == SFD_BYTE &&
                             {24'd0, pcnt_q} >= MIN_PREAMBLE) begin
                    state_d  = S_MAC_DES;
                    busy_d   = 1'b1;
                    crc_d    = CRC_INIT;
                    macCnt_d = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            // A filter miss drops silently; busy stays up until dv falls.
            S_MAC_DES: begin
                if (i_rx_er || !i_rx_dv) begin
                    state_d      = S_DROP;
                    frameError_d = 1'b1;
                end else begin
                    dstMac_d = dstNext;
                    crc_d    = crcByte(crc_q, i_rx_data);
                    macCnt_d = macCnt_q + 3'd1;
                    if (macCnt_q == 3'd5) begin
                        macCnt_d = 3'd0;
                        if (i_mac_filter_en && !dstMatch) state_d = S_DROP;
                        else                               state_d = S_MAC_SRC;
                    end
                end
            end

            S_MAC_SRC: begin
                if (i_rx_er || !i_rx_dv) begin
                    state_d      = S_DROP;
                    frameError_d = 1'b1;
                end else begin
                    srcShift_d = {srcShift_q[39:0], i_rx_data};
                    crc_d      = crcByte(crc_q, i_rx_data);
                    macCnt_d   = macCnt_q + 3'd1;
                    if (macCnt_q == 3'd5) begin
                        macCnt_d = 3'd0;
                        state_d  = S_PAYLOAD;
                        n_d      = 16'd0;
                    end
                end
            end

            // Payload bytes pass through a four-byte delay line so the FCS,
            // only known to be the FCS when dv falls, is never written or
            // folded into the CRC.
            S_PAYLOAD: begin
                if (i_rx_er) begin
                    state_d      = S_DROP;
                    frameError_d = 1'b1;
                end else if (!i_rx_dv) begin
                    state_d     = S_DONE;
                    frameSize_d = n_q - 16'd4;
                    srcMac_d    = srcShift_q;
                    if (n_q < 16'd5 || !fcsGood) frameError_d = 1'b1;
                    else                         frameValid_d = 1'b1;
                end else begin
                    if (n_q >= 16'd4) begin
                        memWrEn_d   = 1'b1;
                        memWrAddr_d = n_q - 16'd4;
                        memWrData_d = dly_q[31:24];
                        crc_d       = crcByte(crc_q, dly_q[31:24]);
                    end
                    dly_d = {dly_q[23:0], i_rx_data};
                    n_d   = nNext;
                    if ({16'd0, nNext} > MAX_PAYLOAD + 32'd4) begin
                        state_d      = S_DROP;
                        frameError_d = 1'b1;
                    end
                end
            end

            S_DROP: begin
                if (!i_rx_dv) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_mem_wr_en   = memWrEn_q;
    assign o_mem_wr_addr = memWrAddr_q;
    assign o_mem_wr_data = memWrData_q;
    assign o_frame_valid = frameValid_q;
    assign o_frame_error = frameError_q;
    assign o_frame_size  = frameSize_q;
    assign o_src_mac     = srcMac_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_eth_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_fsm
//
// Directed bench for eth_rx_fsm. Frames are assembled byte by byte with an
// independently written CRC-32, sent on the negative clock edge, and the DUT
// outputs are observed on the negative edge by a monitor that counts writes
// and pulses. Each scenario task makes its own comparisons.
// ---------------------------------------------------------------------------
module tb_eth_rx_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxDv = 1'b0;
    logic        rxEr = 1'b0;
    logic [7:0]  rxData = 8'd0;
    logic        filterEn = 1'b0;
    logic [47:0] macAddr = 48'd0;
    logic        memWrEn;
    logic [15:0] memWrAddr;
    logic [7:0]  memWrData;
    logic        frameValid;
    logic        frameError;
    logic [15:0] frameSize;
    logic [47:0] srcMac;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Monitor state
    int          cyc = 0;
    int          wrCount = 0;
    int          dataBad = 0;
    int          validCount = 0;
    int          errorCount = 0;
    int          overlapCount = 0;
    int          errCyc = -1;
    int          erCyc = -1;
    logic        busySeen = 1'b0;
    logic [15:0] lastWrAddr = 16'd0;
    logic [7:0]  payloadSeed = 8'd0;

    logic [7:0]  txBytes[$];

    localparam logic [47:0] SRC_A = 48'h1A2B_3C4D_5E6F;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    eth_rx_fsm dut (
        .i_eth_clk       (clk),
        .i_rst           (rst),
        .i_rx_dv         (rxDv),
        .i_rx_er         (rxEr),
        .i_rx_data       (rxData),
        .i_mac_filter_en (filterEn),
        .i_mac_addr      (macAddr),
        .o_mem_wr_en     (memWrEn),
        .o_mem_wr_addr   (memWrAddr),
        .o_mem_wr_data   (memWrData),
        .o_frame_valid   (frameValid),
        .o_frame_error   (frameError),
        .o_frame_size    (frameSize),
        .o_src_mac       (srcMac),
        .o_busy          (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Counts writes and pulses; payload byte i is (i + payloadSeed) mod 256.
    always @(negedge clk) begin
        if (memWrEn) begin
            wrCount++;
            lastWrAddr = memWrAddr;
            if (memWrData !== (memWrAddr[7:0] + payloadSeed)) dataBad++;
        end
        if (frameValid) validCount++;
        if (frameError) begin
            errorCount++;
            errCyc = cyc;
        end
        if (frameValid && frameError) overlapCount++;
        if (busy) busySeen = 1'b1;
    end

    // Bit-serial reference CRC: feedback bit is the LSB of the register
    // XORed with the incoming data bit.
    function automatic logic [31:0] crcModel(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ d[k];
            r  = {1'b0, r[31:1]};
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    task automatic buildFrame(input logic [47:0] dst, input logic [47:0] src,
                              input int payLen, input int preLen);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        txBytes.delete();
        for (int i = 0; i < preLen; i++) txBytes.push_back(8'h55);
        txBytes.push_back(8'hD5);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            b = dst[47 - 8*i -: 8];
            txBytes.push_back(b);
            crc = crcModel(crc, b);
        end
        for (int i = 0; i < 6; i++) begin
            b = src[47 - 8*i -: 8];
            txBytes.push_back(b);
            crc = crcModel(crc, b);
        end
        for (int i = 0; i < payLen; i++) begin
            b = 8'(i) + payloadSeed;
            txBytes.push_back(b);
            crc = crcModel(crc, b);
        end
        fcs = ~crc;
        txBytes.push_back(fcs[7:0]);
        txBytes.push_back(fcs[15:8]);
        txBytes.push_back(fcs[23:16]);
        txBytes.push_back(fcs[31:24]);
    endtask

    // Sends txBytes with dv high, then drives one dv=0 cycle and returns
    // right after that drive.
    task automatic transmit(input int erIdx);
        for (int i = 0; i < txBytes.size(); i++) begin
            @(negedge clk);
            rxDv   = 1'b1;
            rxData = txBytes[i];
            rxEr   = (i == erIdx);
            if (i == erIdx) erCyc = cyc;
        end
        @(negedge clk);
        rxDv   = 1'b0;
        rxEr   = 1'b0;
        rxData = 8'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rxDv   = 1'b0;
            rxEr   = 1'b0;
            rxData = 8'd0;
        end
    endtask

    task automatic clearMon();
        #1;
        wrCount      = 0;
        dataBad      = 0;
        validCount   = 0;
        errorCount   = 0;
        errCyc       = -1;
        busySeen     = 1'b0;
        lastWrAddr   = 16'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if (memWrEn !== 1'b0 || memWrAddr !== 16'd0 || memWrData !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_mem: got en=%b addr=%0d data=%h expected 0", memWrEn, memWrAddr, memWrData);
        end
        checks++;
        if (frameValid !== 1'b0 || frameError !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pulses: got valid=%b error=%b expected 0", frameValid, frameError);
        end
        checks++;
        if (frameSize !== 16'd0 || srcMac !== 48'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: got size=%0d src=%h busy=%b expected 0", frameSize, srcMac, busy);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_accept();
        payloadSeed = 8'd0;
        clearMon();
        buildFrame(BCAST, SRC_A, 60, 7);
        transmit(-1);
        @(negedge clk);
        checks++;
        if (frameValid !== 1'b1 || frameError !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept_pulse: got valid=%b error=%b expected valid=1 error=0", frameValid, frameError);
        end
        idle(3);
        checks++;
        if (wrCount !== 60 || dataBad !== 0 || lastWrAddr !== 16'd59) begin
            errors++;
            $display("[TB] FAIL accept_writes: got count=%0d bad=%0d last=%0d expected 60/0/59", wrCount, dataBad, lastWrAddr);
        end
        checks++;
        if (frameSize !== 16'd60) begin
            errors++;
            $display("[TB] FAIL accept_size: got %0d expected 60", frameSize);
        end
        checks++;
        if (srcMac !== SRC_A) begin
            errors++;
            $display("[TB] FAIL accept_src: got %h expected %h", srcMac, SRC_A);
        end
        checks++;
        if (validCount !== 1 || errorCount !== 0 || busySeen !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept_status: got valid=%0d err=%0d busySeen=%b busy=%b expected 1/0/1/0", validCount, errorCount, busySeen, busy);
        end
    endtask

    task automatic test_bad_fcs();
        clearMon();
        buildFrame(BCAST, SRC_A, 60, 7);
        txBytes[txBytes.size() - 1] = txBytes[txBytes.size() - 1] ^ 8'h01;
        transmit(-1);
        @(negedge clk);
        checks++;
        if (frameError !== 1'b1 || frameValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL badfcs_pulse: got valid=%b error=%b expected valid=0 error=1", frameValid, frameError);
        end
        idle(3);
        checks++;
        if (wrCount !== 60 || validCount !== 0 || errorCount !== 1) begin
            errors++;
            $display("[TB] FAIL badfcs_counts: got wr=%0d valid=%0d err=%0d expected 60/0/1", wrCount, validCount, errorCount);
        end
    endtask

    task automatic test_filter();
        filterEn = 1'b1;
        macAddr  = 48'h0200_0000_0001;
        clearMon();
        buildFrame(48'h0200_0000_0002, SRC_A, 20, 7);
        transmit(-1);
        idle(3);
        checks++;
        if (wrCount !== 0 || validCount !== 0 || errorCount !== 0) begin
            errors++;
            $display("[TB] FAIL filter_miss: got wr=%0d valid=%0d err=%0d expected 0/0/0", wrCount, validCount, errorCount);
        end
        checks++;
        if (busySeen !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL filter_busy: got seen=%b now=%b expected 1/0", busySeen, busy);
        end
        clearMon();
        buildFrame(48'h0200_0000_0001, SRC_A, 20, 7);
        transmit(-1);
        idle(3);
        checks++;
        if (validCount !== 1 || errorCount !== 0 || wrCount !== 20) begin
            errors++;
            $display("[TB] FAIL filter_hit: got valid=%0d err=%0d wr=%0d expected 1/0/20", validCount, errorCount, wrCount);
        end
        clearMon();
        buildFrame(BCAST, SRC_A, 20, 7);
        transmit(-1);
        idle(3);
        checks++;
        if (validCount !== 1 || errorCount !== 0) begin
            errors++;
            $display("[TB] FAIL filter_bcast: got valid=%0d err=%0d expected 1/0", validCount, errorCount);
        end
        filterEn = 1'b0;
    endtask

    task automatic test_preamble();
        clearMon();
        buildFrame(BCAST, SRC_A, 10, 1);
        transmit(-1);
        idle(3);
        checks++;
        if (busySeen !== 1'b0 || wrCount !== 0 || validCount !== 0 || errorCount !== 0) begin
            errors++;
            $display("[TB] FAIL short_preamble: got busySeen=%b wr=%0d valid=%0d err=%0d expected 0/0/0/0", busySeen, wrCount, validCount, errorCount);
        end
        clearMon();
        buildFrame(BCAST, 48'h0011_2233_4455, 4, 2);
        transmit(-1);
        idle(3);
        checks++;
        if (validCount !== 1 || frameSize !== 16'd4 || wrCount !== 4 || srcMac !== 48'h0011_2233_4455) begin
            errors++;
            $display("[TB] FAIL min_frame: got valid=%0d size=%0d wr=%0d src=%h expected 1/4/4/001122334455", validCount, frameSize, wrCount, srcMac);
        end
        clearMon();
        buildFrame(BCAST, SRC_A, 0, 7);
        void'(txBytes.pop_back());
        transmit(-1);
        idle(3);
        checks++;
        if (errorCount !== 1 || validCount !== 0 || wrCount !== 0) begin
            errors++;
            $display("[TB] FAIL runt: got err=%0d valid=%0d wr=%0d expected 1/0/0", errorCount, validCount, wrCount);
        end
    endtask

    task automatic test_rx_er();
        clearMon();
        buildFrame(BCAST, SRC_A, 40, 7);
        transmit(7 + 1 + 12 + 10);
        idle(3);
        checks++;
        if (errorCount !== 1 || validCount !== 0) begin
            errors++;
            $display("[TB] FAIL rxer_counts: got err=%0d valid=%0d expected 1/0", errorCount, validCount);
        end
        checks++;
        if (errCyc !== erCyc + 1) begin
            errors++;
            $display("[TB] FAIL rxer_latency: got pulse cycle %0d expected %0d", errCyc, erCyc + 1);
        end
    endtask

    task automatic test_oversize();
        clearMon();
        buildFrame(BCAST, SRC_A, 1505, 7);
        transmit(-1);
        idle(3);
        checks++;
        if (errorCount !== 1 || validCount !== 0) begin
            errors++;
            $display("[TB] FAIL oversize_pulse: got err=%0d valid=%0d expected 1/0", errorCount, validCount);
        end
        checks++;
        if (wrCount !== 1505 || lastWrAddr !== 16'd1504 || dataBad !== 0) begin
            errors++;
            $display("[TB] FAIL oversize_writes: got wr=%0d last=%0d bad=%0d expected 1505/1504/0", wrCount, lastWrAddr, dataBad);
        end
    endtask

    task automatic test_reset_midframe();
        buildFrame(BCAST, SRC_A, 60, 7);
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            rxDv   = 1'b1;
            rxData = txBytes[i];
        end
        for (int i = 45; i < 47; i++) begin
            @(negedge clk);
            rst    = 1'b1;
            rxData = txBytes[i];
        end
        @(negedge clk);
        rst    = 1'b0;
        rxData = txBytes[47];
        clearMon();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rxDv   = 1'b1;
            rxData = (k < 10) ? 8'h55 : ((k == 10) ? 8'hD5 : 8'(k));
        end
        idle(4);
        checks++;
        if (wrCount !== 0 || validCount !== 0 || errorCount !== 0 || busySeen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got wr=%0d valid=%0d err=%0d busySeen=%b expected 0/0/0/0", wrCount, validCount, errorCount, busySeen);
        end
        clearMon();
        buildFrame(BCAST, 48'hA0B0_C0D0_E0F0, 12, 7);
        transmit(-1);
        idle(3);
        checks++;
        if (validCount !== 1 || frameSize !== 16'd12 || srcMac !== 48'hA0B0_C0D0_E0F0) begin
            errors++;
            $display("[TB] FAIL reset_recover: got valid=%0d size=%0d src=%h expected 1/12/a0b0c0d0e0f0", validCount, frameSize, srcMac);
        end
    endtask

    task automatic test_back_to_back();
        clearMon();
        buildFrame(BCAST, SRC_A, 60, 7);
        transmit(-1);
        buildFrame(BCAST, 48'h0606_0505_0404, 30, 7);
        transmit(-1);
        idle(3);
        checks++;
        if (validCount !== 2 || errorCount !== 0 || wrCount !== 90) begin
            errors++;
            $display("[TB] FAIL b2b_counts: got valid=%0d err=%0d wr=%0d expected 2/0/90", validCount, errorCount, wrCount);
        end
        checks++;
        if (frameSize !== 16'd30 || srcMac !== 48'h0606_0505_0404) begin
            errors++;
            $display("[TB] FAIL b2b_last: got size=%0d src=%h expected 30/060605050404", frameSize, srcMac);
        end
        checks++;
        if (overlapCount !== 0) begin
            errors++;
            $display("[TB] FAIL pulse_overlap: got %0d cycles expected 0", overlapCount);
        end
    endtask

    initial begin
        $display("[TB] eth_rx_fsm directed test start");
        test_reset();
        test_accept();
        test_bad_fcs();
        test_filter();
        test_preamble();
        test_rx_er();
        test_oversize();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
